unary_accum_param: RTL and testbench

UNARY_ACCUM_PARAM -- requirements
Module: unary_accum_param

---
 rtl/unary_pkg.sv | 21 ++
 rtl/unary_popcount.sv | 25 ++
 rtl/unary_accum_param.sv | 105 ++++++++++
 tb/tb_unary_accum_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
`default_nettype none
// ============================================================================
// Module   : unary_pkg
// Purpose  : Shared state encoding and mode constants for the unary
//            accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package unary_pkg;

  // Operating state of the accumulator; tracks the registered mode input.
  typedef enum logic [0:0] {
    S_ACC   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  // Encoding of the mode input pin.
  localparam logic MODE_ACC   = 1'b0;
  localparam logic MODE_DRAIN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/unary_popcount.sv
`default_nettype none
// ============================================================================
// Module   : unary_popcount
// Purpose  : Purely combinational population count of LANES unary bits.
// Revision : 1.0 - initial release
// ============================================================================
module unary_popcount #(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0]             i_din,
  output logic [$clog2(LANES+1)-1:0]   o_pop
);

  localparam int PW = $clog2(LANES + 1);

  // Sum every set lane into the result.
  always_comb begin
    o_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      o_pop = o_pop + PW'(i_din[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/unary_accum_param.sv
`default_nettype none
// ============================================================================
// Module   : unary_accum_param
// Purpose  : Accumulates the popcount of LANES unary input bits per cycle,
//            with overflow carry pulse, and drains the count as a serial
//            unary stream with a done pulse when it empties.
// Options  : UNARY_ACCUM_SAT_EN - when defined, overflow saturates the count
//            at MAX_COUNT instead of wrapping modulo (MAX_COUNT+1).
// Revision : 1.0 - initial release
// ============================================================================
module unary_accum_param
  import unary_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int MAX_COUNT = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  mode,
  input  logic [LANES-1:0]                      din,
  output logic                                  dout,
  output logic                                  carry,
  output logic                                  done,
  output logic [$clog2(MAX_COUNT+LANES+1)-1:0]  count_o
);

  localparam int CW = $clog2(MAX_COUNT + LANES + 1);
  localparam int PW = $clog2(LANES + 1);

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_dout;
  logic            r_carry;
  logic            r_done;

  logic [PW-1:0]   w_pop;
  logic [CW-1:0]   w_sum;
  state_t          w_next_state;
  logic [CW-1:0]   w_next_count;
  logic            w_next_dout;
  logic            w_next_carry;
  logic            w_next_done;

  unary_popcount #(
    .LANES (LANES)
  ) u_popcount (
    .i_din (din),
    .o_pop (w_pop)
  );

  // Next-state and next-output decode; the incoming mode takes effect on the
  // same edge it is sampled, so the rule is chosen from the next state.
  always_comb begin
    w_sum        = r_count + CW'(w_pop);
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_dout  = 1'b0;
    w_next_carry = 1'b0;
    w_next_done  = 1'b0;
    if (en) begin
      w_next_state = (mode == MODE_DRAIN) ? S_DRAIN : S_ACC;
      if (w_next_state == S_ACC) begin
        if (w_sum > CW'(MAX_COUNT)) begin
`ifdef UNARY_ACCUM_SAT_EN
          w_next_count = CW'(MAX_COUNT);
`else
          w_next_count = w_sum - CW'(MAX_COUNT + 1);
`endif
          w_next_carry = 1'b1;
        end else begin
          w_next_count = w_sum;
        end
      end else if (r_count != '0) begin
        w_next_dout  = 1'b1;
        w_next_count = r_count - CW'(1);
        w_next_done  = (r_count == CW'(1));
      end
    end
  end

  // Single clocked process holding all state; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ACC;
      r_count <= '0;
      r_dout  <= 1'b0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_dout  <= w_next_dout;
      r_carry <= w_next_carry;
      r_done  <= w_next_done;
    end
  end

  assign dout    = r_dout;
  assign carry   = r_carry;
  assign done    = r_done;
  assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_unary_accum_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_unary_accum_param
// Purpose  : Self-checking bench for unary_accum_param (LANES=4,
//            MAX_COUNT=16) using a behavioural model plus literal checks.
//            Honours UNARY_ACCUM_SAT_EN for overflow expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unary_accum_param;
  import unary_pkg::*;

  localparam int LANES = 4;
  localparam int MAXC  = 16;
  localparam int CW    = $clog2(MAXC + LANES + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          mode = 1'b0;
  logic [3:0]    din = 4'h0;
  logic          dout;
  logic          carry;
  logic          done;
  logic [CW-1:0] count_o;

  int n_vec    = 0;
  int n_miscmp = 0;

  // Behavioural expectation
  int ex_count = 0;
  int ex_dout  = 0;
  int ex_carry = 0;
  int ex_done  = 0;

  unary_accum_param #(
    .LANES     (LANES),
    .MAX_COUNT (MAXC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .din     (din),
    .dout    (dout),
    .carry   (carry),
    .done    (done),
    .count_o (count_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the sampled inputs, then compare every cycle
  always @(posedge clk) begin
    int s;
    if (rst) begin
      ex_count = 0; ex_dout = 0; ex_carry = 0; ex_done = 0;
    end else if (!en) begin
      ex_dout = 0; ex_carry = 0; ex_done = 0;
    end else if (mode == 1'b0) begin
      s = ex_count + $countones(din);
      ex_dout = 0; ex_done = 0;
      if (s > MAXC) begin
`ifdef UNARY_ACCUM_SAT_EN
        ex_count = MAXC;
`else
        ex_count = s % (MAXC + 1);
`endif
        ex_carry = 1;
      end else begin
        ex_count = s;
        ex_carry = 0;
      end
    end else begin
      ex_carry = 0;
      ex_done  = (ex_count == 1) ? 1 : 0;
      ex_dout  = (ex_count > 0) ? 1 : 0;
      if (ex_count > 0) ex_count = ex_count - 1;
    end
    #1;
    chk("model_count", int'(count_o), ex_count);
    chk("model_dout",  int'(dout),    ex_dout);
    chk("model_carry", int'(carry),   ex_carry);
    chk("model_done",  int'(done),    ex_done);
  end

  task automatic step(input logic r, input logic e, input logic m, input logic [3:0] d);
    @(negedge clk);
    rst = r; en = e; mode = m; din = d;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string tag, input int c, input int o, input int cy, input int dn);
    chk({tag, "_count"}, int'(count_o), c);
    chk({tag, "_dout"},  int'(dout),    o);
    chk({tag, "_carry"}, int'(carry),   cy);
    chk({tag, "_done"},  int'(done),    dn);
  endtask

  initial begin
    int acc_exp[4];
    int drn_cnt[4];
    int drn_out[4];
    int drn_dn[4];
    acc_exp = '{3, 6, 9, 12};
    drn_cnt = '{2, 1, 0, 0};
    drn_out = '{1, 1, 1, 0};
    drn_dn  = '{0, 0, 1, 0};

    // Reset state
    step(1, 0, 0, 4'h0);
    step(1, 1, 1, 4'hF);
    lit("reset", 0, 0, 0, 0);
    chk("reset_state", int'(dut.r_state), int'(S_ACC));

    // Accumulate 4'b1011 four times
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 4'b1011);
      lit($sformatf("acc%0d", i), acc_exp[i], 0, 0, 0);
    end

    // Reach 15, then overflow with 2 more
    step(0, 1, 0, 4'b0111);
    lit("acc15", 15, 0, 0, 0);
    step(0, 1, 0, 4'b0011);
`ifdef UNARY_ACCUM_SAT_EN
    lit("ovf", 16, 0, 1, 0);
    step(0, 1, 0, 4'b0000);
    lit("ovf_after", 16, 0, 0, 0);
`else
    lit("ovf", 0, 0, 1, 0);
    step(0, 1, 0, 4'b0000);
    lit("ovf_after", 0, 0, 0, 0);
`endif

    // Drain from 3
    step(1, 0, 0, 4'h0);
    step(0, 1, 0, 4'b0111);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 4'hF);
      lit($sformatf("drain%0d", i), drn_cnt[i], drn_out[i], 0, drn_dn[i]);
    end

    // Enable hold at 5
    step(1, 0, 0, 4'h0);
    step(0, 1, 0, 4'hF);
    step(0, 1, 0, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 4'hF);
      lit($sformatf("hold%0d", i), 5, 0, 0, 0);
    end

    // Mid-drain switch back to accumulate
    step(1, 0, 0, 4'h0);
    step(0, 1, 0, 4'hF);
    step(0, 1, 0, 4'b0011);
    step(0, 1, 1, 4'h0);
    step(0, 1, 1, 4'h0);
    lit("switch_drain", 4, 1, 0, 0);
    step(0, 1, 0, 4'b0001);
    lit("switch_acc", 5, 0, 0, 0);

    // Reset mid-drain
    step(1, 0, 0, 4'h0);
    step(0, 1, 0, 4'hF);
    step(0, 1, 0, 4'hF);
    step(0, 1, 1, 4'h0);
    lit("pre_rst", 7, 1, 0, 0);
    step(1, 1, 1, 4'h0);
    lit("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_state", int'(dut.r_state), int'(S_ACC));
    step(0, 0, 1, 4'h0);
    lit("post_rst", 0, 0, 0, 0);

    // Overflow by a full lane set from 14, and en gaps inside a drain
    step(0, 1, 0, 4'hF);
    step(0, 1, 0, 4'hF);
    step(0, 1, 0, 4'hF);
    step(0, 1, 0, 4'b0011);
    step(0, 1, 0, 4'hF);
    step(0, 1, 0, 4'h0);
    step(1, 0, 0, 4'h0);
    step(0, 1, 0, 4'b0111);
    step(0, 1, 1, 4'h0);
    step(0, 0, 0, 4'hF);
    step(0, 1, 1, 4'hF);
    step(0, 1, 1, 4'h0);
    step(0, 1, 1, 4'h0);
    step(0, 1, 0, 4'b1000);
    step(0, 1, 1, 4'h0);
    step(0, 1, 1, 4'h0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
